// File: rtl/npu_pkg.sv
// Shared NPU definitions: requantizer widths, INT8 limits and pipeline payloads.
package npu_pkg;

   localparam int unsigned ACC_W     = 32;
   localparam int unsigned MULT_W    = 16;
   localparam int unsigned SHIFT_W   = 6;
   localparam int unsigned OUT_W     = 8;
   localparam int unsigned SHIFT_MAX = 48;
   localparam int unsigned CNT_W     = 16;

   // acc + bias never wraps; the product of that sum and the zero-extended
   // multiplier fits PROD_W; rounding needs one more bit of headroom.
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned PROD_W = SUM_W + MULT_W;
   localparam int unsigned RND_W  = PROD_W + 1;

   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;

   // Stage 1 payload: biased sum plus the configuration that travels with it.
   typedef struct packed {
      logic signed [SUM_W-1:0]  sum;
      logic        [MULT_W-1:0] mult;
      logic        [SHIFT_W-1:0] shift;
      logic                     relu;
   } s1_t;

   // Stage 2 payload: scaled product plus remaining configuration.
   typedef struct packed {
      logic signed [PROD_W-1:0] prod;
      logic        [SHIFT_W-1:0] shift;
      logic                     relu;
   } s2_t;

   // Shift amounts above SHIFT_MAX behave as SHIFT_MAX.
   function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] sh);
      return (sh > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : sh;
   endfunction

endpackage

// File: rtl/requant_round_sat.sv
// Combinational round-half-up, arithmetic right shift, optional ReLU and
// INT8 clamp of a scaled product.
//   prod   : signed scaled product
//   shift  : right-shift amount (already limited to SHIFT_MAX)
//   relu   : force negative results to zero
//   data_c : signed INT8 result
//   sat_c  : clamp changed the value
module requant_round_sat
   import npu_pkg::*;
(
   input  logic signed [PROD_W-1:0]  prod,
   input  logic        [SHIFT_W-1:0] shift,
   input  logic                      relu,
   output logic signed [OUT_W-1:0]   data_c,
   output logic                      sat_c
);

   localparam logic signed [RND_W-1:0] HI = RND_W'(INT8_MAX);
   localparam logic signed [RND_W-1:0] LO = RND_W'(INT8_MIN);

   logic signed [RND_W-1:0] ext_c;
   logic signed [RND_W-1:0] half_c;
   logic signed [RND_W-1:0] rnd_c;
   logic signed [RND_W-1:0] act_c;

   // Round, shift, rectify, clamp.
   always_comb begin
      ext_c  = RND_W'(prod);
      half_c = '0;
      rnd_c  = ext_c;
      if (shift != '0) begin
         half_c = {{(RND_W-1){1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
         rnd_c  = (ext_c + half_c) >>> shift;
      end

      act_c = (relu && rnd_c[RND_W-1]) ? '0 : rnd_c;

      data_c = OUT_W'(act_c);
      sat_c  = 1'b0;
      if (act_c > HI) begin
         data_c = OUT_W'(INT8_MAX);
         sat_c  = 1'b1;
      end else if (act_c < LO) begin
         data_c = OUT_W'(INT8_MIN);
         sat_c  = 1'b1;
      end
   end

endmodule

// File: rtl/requant_unit.sv
// Three-stage INT32 -> INT8 requantizer with per-beat configuration and a
// saturating count of clipped output beats.
//   s_valid/s_ready : input handshake; s_acc, s_bias, s_mult, s_shift, s_relu
//                     are captured on transfer
//   m_valid/m_ready : output handshake; m_data (INT8), m_sat (beat clipped)
//   cnt_clr         : synchronous clear of sat_count
//   sat_count       : clipped beats delivered, saturating at all-ones
module requant_unit
   import npu_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic signed [ACC_W-1:0]   s_acc,
   input  logic signed [ACC_W-1:0]   s_bias,
   input  logic        [MULT_W-1:0]  s_mult,
   input  logic        [SHIFT_W-1:0] s_shift,
   input  logic                      s_relu,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic signed [OUT_W-1:0]   m_data,
   output logic                      m_sat,
   input  logic                      cnt_clr,
   output logic        [CNT_W-1:0]   sat_count
);

   logic v1_q, v1_d;
   logic v2_q, v2_d;
   logic v3_q, v3_d;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;
   logic signed [OUT_W-1:0] data_q, data_d;
   logic                    sat_q,  sat_d;
   logic [CNT_W-1:0]        cnt_q,  cnt_d;

   logic ld1_c, ld2_c, ld3_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [OUT_W-1:0]  rs_data_c;
   logic                     rs_sat_c;

   requant_round_sat u_round_sat (
      .prod   (s2_q.prod),
      .shift  (s2_q.shift),
      .relu   (s2_q.relu),
      .data_c (rs_data_c),
      .sat_c  (rs_sat_c)
   );

   // Next-state: a stage loads when empty or when its beat moves on this cycle.
   always_comb begin
      ld3_c = !v3_q || m_ready;
      ld2_c = !v2_q || ld3_c;
      ld1_c = !v1_q || ld2_c;

      v1_d   = v1_q;
      v2_d   = v2_q;
      v3_d   = v3_q;
      s1_d   = s1_q;
      s2_d   = s2_q;
      data_d = data_q;
      sat_d  = sat_q;
      cnt_d  = cnt_q;

      prod_c = PROD_W'(s1_q.sum) * PROD_W'($signed({1'b0, s1_q.mult}));

      if (ld1_c) begin
         v1_d = s_valid;
         if (s_valid) begin
            s1_d.sum   = SUM_W'(s_acc) + SUM_W'(s_bias);
            s1_d.mult  = s_mult;
            s1_d.shift = clamp_shift(s_shift);
            s1_d.relu  = s_relu;
         end
      end

      if (ld2_c) begin
         v2_d = v1_q;
         if (v1_q) begin
            s2_d.prod  = prod_c;
            s2_d.shift = s1_q.shift;
            s2_d.relu  = s1_q.relu;
         end
      end

      if (ld3_c) begin
         v3_d = v2_q;
         if (v2_q) begin
            data_d = rs_data_c;
            sat_d  = rs_sat_c;
         end
      end

      // Clear takes priority over a simultaneous clipped-beat delivery.
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (v3_q && m_ready && sat_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         data_q <= '0;
         sat_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         data_q <= data_d;
         sat_q  <= sat_d;
         cnt_q  <= cnt_d;
      end
   end

   // Datapath payload registers; qualified by the valid bits, so no reset.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
   end

   assign s_ready   = ld1_c;
   assign m_valid   = v3_q;
   assign m_data    = data_q;
   assign m_sat     = sat_q;
   assign sat_count = cnt_q;

endmodule

// File: tb/tb_requant_unit.sv
module tb_requant_unit;

   logic               clk;
   logic               rst_n;
   logic               s_valid;
   logic               s_ready;
   logic signed [31:0] s_acc;
   logic signed [31:0] s_bias;
   logic        [15:0] s_mult;
   logic        [5:0]  s_shift;
   logic               s_relu;
   logic               m_valid;
   logic               m_ready;
   logic signed [7:0]  m_data;
   logic               m_sat;
   logic               cnt_clr;
   logic        [15:0] sat_count;

   requant_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_acc     (s_acc),
      .s_bias    (s_bias),
      .s_mult    (s_mult),
      .s_shift   (s_shift),
      .s_relu    (s_relu),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_sat     (m_sat),
      .cnt_clr   (cnt_clr),
      .sat_count (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint data;
      bit     sat;
      int     cyc;
   } exp_t;

   exp_t   exp_q[$];
   longint got_q[$];
   int     n_assert = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   longint cnt_model = 0;
   longint last_data = 0;
   bit     last_sat  = 0;
   bit     accepted  = 0;
   bit     lat_chk   = 0;
   bit     rand_ready = 0;
   bit     clr_on_sat = 0;
   bit     saw_block  = 0;
   bit     hold_pending = 0;
   longint hold_val   = 0;
   int     n_out      = 0;
   int     stall_start = -1;
   int     stall_end   = -1;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the requantization rules.
   function automatic exp_t model(input logic signed [31:0] acc, input logic signed [31:0] bias,
                                  input logic [15:0] mult, input logic [5:0] shift, input bit relu);
      exp_t   e;
      longint sum, prod, r;
      int     sh;
      sum  = longint'(acc) + longint'(bias);
      prod = sum * longint'(mult);
      sh   = (shift > 6'd48) ? 48 : int'(shift);
      if (sh == 0) r = prod;
      else r = (prod + (longint'(1) << (sh - 1))) >>> sh;
      if (relu && r < 0) r = 0;
      e.sat = 1'b0;
      if (r > 127) begin r = 127; e.sat = 1'b1; end
      else if (r < -128) begin r = -128; e.sat = 1'b1; end
      e.data = r;
      e.cyc  = cyc;
      return e;
   endfunction

   // One clock: settle, check outputs against the scoreboard, advance.
   task automatic tick();
      bit   in_x, out_x;
      exp_t e;
      if (cyc >= stall_start && cyc < stall_end) m_ready = 1'b0;
      else if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
      else m_ready = 1'b1;
      #1;
      if (clr_on_sat && m_valid && m_ready && m_sat) cnt_clr = 1'b1;
      #1;
      check("sat_count", longint'(sat_count), cnt_model);
      if (hold_pending) check("hold_stable", longint'({m_sat, m_data}), hold_val);
      if (!s_ready) saw_block = 1'b1;
      in_x  = s_valid && s_ready;
      out_x = m_valid && m_ready;
      if (out_x) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("spurious_beat", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("m_data", longint'(m_data), e.data);
            check("m_sat", longint'(m_sat), longint'(e.sat));
            if (lat_chk) check("latency", cyc - e.cyc, 3);
            got_q.push_back(longint'(m_data));
            last_data = longint'(m_data);
            last_sat  = m_sat;
            if (!cnt_clr && e.sat && cnt_model < 65535) cnt_model++;
         end
      end
      if (cnt_clr) cnt_model = 0;
      hold_pending = m_valid && !m_ready;
      hold_val     = longint'({m_sat, m_data});
      if (in_x) exp_q.push_back(model(s_acc, s_bias, s_mult, s_shift, s_relu));
      accepted = in_x;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      cnt_clr = 1'b0;
   endtask

   task automatic send(input logic signed [31:0] acc, input logic signed [31:0] bias,
                       input logic [15:0] mult, input logic [5:0] shift, input bit relu);
      s_acc = acc; s_bias = bias; s_mult = mult; s_shift = shift; s_relu = relu;
      s_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (accepted) return;
      end
      check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      s_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) return;
         tick();
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; cnt_clr = 1'b0;
      s_acc = '0; s_bias = '0; s_mult = '0; s_shift = '0; s_relu = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_m_valid", longint'(m_valid), 0);
      check("rst_s_ready", longint'(s_ready), 1);
      check("rst_m_data", longint'(m_data), 0);
      check("rst_m_sat", longint'(m_sat), 0);
      check("rst_sat_count", longint'(sat_count), 0);
      rst_n = 1'b1;

      // Positive and negative saturation through the unwrapped 33-bit sum.
      send(32'sh7FFFFFFF, 32'sd1, 16'd65535, 6'd0, 1'b0);
      drain();
      check("sat_pos_data", last_data, 127);
      check("sat_pos_flag", longint'(last_sat), 1);
      check("sat_pos_count", longint'(sat_count), 1);
      send(32'sh80000000, -32'sd1, 16'd65535, 6'd0, 1'b0);
      drain();
      check("sat_neg_data", last_data, -128);
      check("sat_neg_count", longint'(sat_count), 2);

      // Rounding, latency and ReLU.
      lat_chk = 1'b1;
      send(32'sd1000, 32'sd0, 16'd1, 6'd4, 1'b0);
      drain();
      check("round_pos", last_data, 63);
      check("round_pos_sat", longint'(last_sat), 0);
      send(-32'sd24, 32'sd0, 16'd1, 6'd4, 1'b0);
      drain();
      check("round_neg", last_data, -1);
      send(-32'sd500, 32'sd0, 16'd1, 6'd0, 1'b1);
      drain();
      check("relu_data", last_data, 0);
      check("relu_sat", longint'(last_sat), 0);
      send(-32'sd500, 32'sd0, 16'd1, 6'd0, 1'b0);
      drain();
      check("norelu_data", last_data, -128);
      check("norelu_sat", longint'(last_sat), 1);
      send(32'sd1, 32'sd0, 16'd1, 6'd63, 1'b0);
      drain();
      check("shift_clamp", last_data, 0);
      lat_chk = 1'b0;

      // Back-to-back stream with a 5-cycle output stall.
      got_q.delete();
      n_out = 0;
      saw_block = 1'b0;
      check("bp_ready_start", longint'(s_ready), 1);
      stall_start = cyc + 4;
      stall_end   = stall_start + 5;
      for (int i = 0; i < 8; i++) send(32'(i), 32'sd0, 16'd1, 6'd0, 1'b0);
      drain();
      stall_start = -1;
      stall_end   = -1;
      check("bp_s_ready_fell", longint'(saw_block), 1);
      check("bp_count", n_out, 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) check("bp_order", got_q[i], longint'(i));

      // Clear coincident with a clipped-beat delivery.
      clr_on_sat = 1'b1;
      send(-32'sd500, 32'sd0, 16'd1, 6'd0, 1'b0);
      drain();
      clr_on_sat = 1'b0;
      check("clr_wins", longint'(sat_count), 0);

      // Reset with two beats in flight.
      send(32'sd5, 32'sd0, 16'd1, 6'd0, 1'b0);
      send(32'sd6, 32'sd0, 16'd1, 6'd0, 1'b0);
      s_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      cnt_model = 0;
      hold_pending = 1'b0;
      tick();
      tick();
      check("mid_rst_m_valid", longint'(m_valid), 0);
      check("mid_rst_s_ready", longint'(s_ready), 1);
      rst_n = 1'b1;
      n_out = 0;
      for (int i = 0; i < 8; i++) tick();
      check("post_rst_outputs", n_out, 0);
      check("post_rst_m_valid", longint'(m_valid), 0);

      // Randomized traffic with random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            s_acc   = 32'(int'($urandom_range(0, 4000)) - 2000);
            s_shift = 6'($urandom_range(0, 8));
            s_mult  = 16'($urandom_range(0, 300));
         end else begin
            s_acc   = 32'($urandom);
            s_shift = 6'($urandom_range(20, 63));
            s_mult  = 16'($urandom);
         end
         s_bias = 32'(int'($urandom_range(0, 2000)) - 1000);
         s_relu = 1'($urandom_range(0, 1));
         tick();
      end
      rand_ready = 1'b0;
      drain();
      check("final_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
